adm_encoder: RTL

Adaptive delta-modulation encoder: converts 12-bit offset-binary samples into the 1-bit stream consumed by the on-chip DSM-to-binary decoder. It keeps a bit-exact model of that decoder: step history, adaptive scale and saturating accumulator. The emitted bitstream therefore reconstructs the input within one step. It sits on the loopback/test path between the sample source (pattern generator or ADC capture) and the DSM serial line.

---
 rtl/adm_encoder.sv | 116 +++++++++++
 1 files changed

// File: rtl/adm_encoder.sv
// rtl/adm_encoder.sv - adaptive delta-modulation encoder with bit-exact decoder model
// Optional feature macro: ADM_ADAPT_EN (adaptive scale); undefined keeps scale fixed at 1.
module adm_encoder #(
  parameter int DATA_W   = 12,
  parameter int SCALE_W  = 8,
  parameter int HIST_LEN = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [DATA_W-1:0]  sample_in,
  input  logic               sample_valid,
  output logic               sample_ready,
  output logic               dsm_out,
  output logic               dsm_valid,
  output logic [SCALE_W-1:0] scale_out,
  output logic [DATA_W-1:0]  acc_out
);

  localparam logic [DATA_W-1:0]          MID      = DATA_W'(1) << (DATA_W - 1);
  localparam logic [HIST_LEN-1:0]        HIST_RST = HIST_LEN'(5'b10100);
  localparam logic signed [DATA_W+1:0]   ACC_LIM  = (DATA_W + 2)'((1 << DATA_W) - 1);
  localparam logic signed [DATA_W+1:0]   ZERO     = '0;
`ifdef ADM_ADAPT_EN
  localparam logic [SCALE_W-1:0]         SCALE_MAX = SCALE_W'(1) << (SCALE_W - 1);
`endif

  logic [DATA_W-1:0]   tgt_q, tgt_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [SCALE_W-1:0]  scale_q, scale_d;
  logic [HIST_LEN-1:0] hist_q, hist_d;
  logic                dsm_q, dsm_d;
  logic                valid_q, valid_d;
  logic                ready_q;

  logic                       bit_c;
  logic [HIST_LEN-1:0]        hist_c;
  logic [SCALE_W-1:0]         scale_c;
  logic signed [DATA_W+1:0]   sum_c;
  logic signed [DATA_W+1:0]   diff_c;
  logic                       unused_hist;

  // The oldest history bit is shifted out before anything looks at it.
  assign unused_hist = hist_q[HIST_LEN-1];

  always_comb begin
    tgt_d   = sample_valid ? sample_in : tgt_q;
    valid_d = en;
    dsm_d   = dsm_q;
    hist_d  = hist_q;
    scale_d = scale_q;
    acc_d   = acc_q;

    if (tgt_q > acc_q) begin
      bit_c = 1'b1;
    end else if (tgt_q < acc_q) begin
      bit_c = 1'b0;
    end else begin
      bit_c = ~hist_q[0];
    end
    hist_c = {hist_q[HIST_LEN-2:0], bit_c};

`ifdef ADM_ADAPT_EN
    scale_c = scale_q;
    if (((&hist_c) || !(|hist_c)) && (scale_q < SCALE_MAX)) begin
      scale_c = scale_q << 1;
    end else if ((hist_c[0] != hist_c[1]) && (hist_c[1] != hist_c[2]) && (scale_q > SCALE_W'(1))) begin
      scale_c = scale_q >> 1;
    end
`else
    scale_c = SCALE_W'(1);
`endif

    // Widened signed checks so the accumulator saturates instead of wrapping.
    sum_c  = (DATA_W + 2)'(acc_q) + (DATA_W + 2)'(scale_c);
    diff_c = (DATA_W + 2)'(acc_q) - (DATA_W + 2)'(scale_c);

    if (en) begin
      dsm_d   = bit_c;
      hist_d  = hist_c;
      scale_d = scale_c;
      if (bit_c) begin
        if (sum_c < ACC_LIM) acc_d = acc_q + DATA_W'(scale_c);
      end else begin
        if (diff_c >= ZERO) acc_d = acc_q - DATA_W'(scale_c);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgt_q   <= MID;
      acc_q   <= MID;
      scale_q <= SCALE_W'(1);
      hist_q  <= HIST_RST;
      dsm_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      tgt_q   <= tgt_d;
      acc_q   <= acc_d;
      scale_q <= scale_d;
      hist_q  <= hist_d;
      dsm_q   <= dsm_d;
      valid_q <= valid_d;
      ready_q <= 1'b1;
    end
  end

  assign sample_ready = ready_q;
  assign dsm_out      = dsm_q;
  assign dsm_valid    = valid_q;
  assign scale_out    = scale_q;
  assign acc_out      = acc_q;

endmodule
